psum_buffer: RTL and testbench

- Scratch store on the far end of the PE-array psum interface.
- MODE1: captures bottom-row (row5) psums from each of 7 columns and acknowledges them.
- MODE2: replays the stored psums into top-row (row0) PE inputs with valid/ack handshake, so accumulation can span passes.
- Sits between the PE array and the controller. One independent buffer per column.

---
 rtl/psum_buffer_pkg.sv | 31 +++
 rtl/psum_col_buf.sv | 100 ++++++++++
 rtl/psum_buffer.sv | 116 +++++++++++
 tb/tb_psum_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/psum_buffer_pkg.sv
// Shared types and constants for the partial-sum scratch buffer.
package psum_buffer_pkg;

  // Number of PE-array columns served by the buffer.
  localparam int NUM_COLS = 7;

  // Width of one partial sum carried across the PE-array interface.
  localparam int PKG_PSUM_W = 16;

  // Operating modes requested by the controller.
  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } OP_MODE;

  // One partial sum plus its valid qualifier.
  typedef struct packed {
    logic                  valid;
    logic [PKG_PSUM_W-1:0] data;
  } PSUM_PACKET;

  // Buffer-level operating state.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_REPLAY  = 2'd2
  } buf_state_e;

endpackage : psum_buffer_pkg

// File: rtl/psum_col_buf.sv
// Single-column psum store: captures bottom-row psums in capture mode and
// replays them first-word-fall-through, non-destructively, in replay mode.
module psum_col_buf
  import psum_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PSUM_W = PKG_PSUM_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_en_i,   // buffer is in capture state
  input  logic             replay_en_i,    // buffer is in replay state
  input  logic             change_mode_i,  // mode-change cycle: handshakes blocked
  input  logic             clear_i,        // drop all contents
  input  logic             rewind_i,       // restart replay from the first word
  input  PSUM_PACKET       psum_i,
  output logic             ack_o,
  output PSUM_PACKET       psum_o,
  input  logic             ack_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o,         // everything stored has been replayed
  output logic             err_o           // protocol violation seen this cycle
);

  localparam int AW = $clog2(DEPTH);

  logic [PSUM_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  // Read pointer is one bit wider than the address so it can equal a full count.
  logic [CNT_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              ack_s;
  logic              valid_s;

  // Handshakes, replay data and the per-cycle error term.
  always_comb begin
    ack_s   = capture_en_i & psum_i.valid & (count_q < CNT_W'(DEPTH)) & ~change_mode_i;
    valid_s = replay_en_i & (rd_q < count_q) & ~change_mode_i;
    ack_o   = ack_s;
    psum_o.valid = valid_s;
    if (valid_s) begin
      psum_o.data = mem_q[rd_q[AW-1:0]];
    end else begin
      psum_o.data = '0;
    end
    count_o = count_q;
    done_o  = (rd_q == count_q);
    err_o   = (ack_i & ~valid_s) | (replay_en_i & psum_i.valid);
  end

  // Next-state for write pointer, read pointer and occupancy.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (ack_s) begin
        wr_d    = wr_q + AW'(1);
        count_d = count_q + CNT_W'(1);
      end else begin
        wr_d    = wr_q;
        count_d = count_q;
      end
      if (rewind_i) begin
        rd_d = '0;
      end else if (valid_s & ack_i) begin
        rd_d = rd_q + CNT_W'(1);
      end else begin
        rd_d = rd_q;
      end
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (ack_s) begin
      mem_q[wr_q] <= psum_i.data;
    end
  end

endmodule : psum_col_buf

// File: rtl/psum_buffer.sv
// Partial-sum scratch buffer between the PE array and the controller:
// mode FSM, per-column stores, replay-complete flag and sticky error.
module psum_buffer
  import psum_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PSUM_W = PKG_PSUM_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  OP_MODE                           mode,
  input  logic                             change_mode,
  input  logic                             conv_continue,
  input  PSUM_PACKET [NUM_COLS-1:0]        psum_in,
  output logic       [NUM_COLS-1:0]        psum_ack_out,
  output PSUM_PACKET [NUM_COLS-1:0]        psum_out,
  input  logic       [NUM_COLS-1:0]        psum_ack_in,
  output logic       [NUM_COLS-1:0][CNT_W-1:0] col_count,
  output logic                             replay_done,
  output logic                             error
);

  buf_state_e state_q, state_d;
  OP_MODE     cur_mode_q, cur_mode_d;
  logic       replay_done_q, replay_done_d;
  logic       error_q, error_d;

  logic                clear_s;
  logic                rewind_s;
  logic                capture_en_s;
  logic                replay_en_s;
  logic [NUM_COLS-1:0] col_done_s;
  logic [NUM_COLS-1:0] col_err_s;

  // Mode FSM next state plus the column-wide clear/rewind strobes.
  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    clear_s    = 1'b0;
    rewind_s   = conv_continue;
    if (change_mode) begin
      cur_mode_d = mode;
      case (mode)
        MODE1: begin
          state_d = S_CAPTURE;
          clear_s = 1'b1;
        end
        MODE2: begin
          state_d  = S_REPLAY;
          rewind_s = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d    = state_q;
      cur_mode_d = cur_mode_q;
    end
  end

  // Column enables; the latched mode always agrees with the state it selected.
  always_comb begin
    capture_en_s = (state_q == S_CAPTURE) & (cur_mode_q == MODE1);
    replay_en_s  = (state_q == S_REPLAY)  & (cur_mode_q == MODE2);
  end

  // Replay-complete reduction and sticky error accumulation.
  always_comb begin
    replay_done_d = (state_q == S_REPLAY) & (&col_done_s);
    error_d       = error_q | (|col_err_s);
  end

  // State, latched mode and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_mode_q    <= MODE3;
      replay_done_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_mode_q    <= cur_mode_d;
      replay_done_q <= replay_done_d;
      error_q       <= error_d;
    end
  end

  assign replay_done = replay_done_q;
  assign error       = error_q;

  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    psum_col_buf #(
      .DEPTH  (DEPTH),
      .PSUM_W (PSUM_W),
      .CNT_W  (CNT_W)
    ) u_col (
      .clk           (clk),
      .rst           (rst),
      .capture_en_i  (capture_en_s),
      .replay_en_i   (replay_en_s),
      .change_mode_i (change_mode),
      .clear_i       (clear_s),
      .rewind_i      (rewind_s),
      .psum_i        (psum_in[j]),
      .ack_o         (psum_ack_out[j]),
      .psum_o        (psum_out[j]),
      .ack_i         (psum_ack_in[j]),
      .count_o       (col_count[j]),
      .done_o        (col_done_s[j]),
      .err_o         (col_err_s[j])
    );
  end

endmodule : psum_buffer

// File: tb/tb_psum_buffer.sv
// Self-checking bench for psum_buffer: a cycle model of the buffer produces
// expected handshakes/counts/status, and a scoreboard queue holds the column-0
// words that replay must deliver, popped as the DUT hands them over.
module tb_psum_buffer;
  import psum_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                              clk = 1'b0;
  logic                              rst;
  OP_MODE                            mode;
  logic                              change_mode;
  logic                              conv_continue;
  PSUM_PACKET [NUM_COLS-1:0]         psum_in;
  logic       [NUM_COLS-1:0]         psum_ack_out;
  PSUM_PACKET [NUM_COLS-1:0]         psum_out;
  logic       [NUM_COLS-1:0]         psum_ack_in;
  logic       [NUM_COLS-1:0][CNT_W-1:0] col_count;
  logic                              replay_done;
  logic                              error;

  psum_buffer #(.DEPTH(DEPTH), .PSUM_W(PKG_PSUM_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .change_mode   (change_mode),
    .conv_continue (conv_continue),
    .psum_in       (psum_in),
    .psum_ack_out  (psum_ack_out),
    .psum_out      (psum_out),
    .psum_ack_in   (psum_ack_in),
    .col_count     (col_count),
    .replay_done   (replay_done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  buf_state_e      m_st;
  int              m_cnt [NUM_COLS];
  int              m_rd  [NUM_COLS];
  int              m_wr  [NUM_COLS];
  logic [15:0]     m_mem [NUM_COLS][DEPTH];
  logic            m_err;
  logic            m_done;
  logic [15:0]     exp_q [$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = S_IDLE;
    m_err  = 1'b0;
    m_done = 1'b0;
    for (int j = 0; j < NUM_COLS; j++) begin
      m_cnt[j] = 0;
      m_rd[j]  = 0;
      m_wr[j]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    mode          = MODE3;
    change_mode   = 1'b0;
    conv_continue = 1'b0;
    psum_in       = '0;
    psum_ack_in   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: inputs already driven; check outputs, then advance the model.
  task automatic cycle();
    PSUM_PACKET [NUM_COLS-1:0]            exp_out;
    logic       [NUM_COLS-1:0]            exp_ack;
    logic       [NUM_COLS-1:0][CNT_W-1:0] exp_cnt;
    logic err_evt, all_done, clear, rewind;
    exp_out = '0;
    exp_ack = '0;
    exp_cnt = '0;
    for (int j = 0; j < NUM_COLS; j++) begin
      exp_ack[j] = (m_st == S_CAPTURE) && psum_in[j].valid && (m_cnt[j] < DEPTH) && !change_mode;
      exp_cnt[j] = CNT_W'(m_cnt[j]);
      if ((m_st == S_REPLAY) && (m_rd[j] < m_cnt[j]) && !change_mode) begin
        exp_out[j].valid = 1'b1;
        exp_out[j].data  = m_mem[j][m_rd[j] % DEPTH];
      end
    end
    #3;
    check_val("psum_ack_out", 128'(psum_ack_out), 128'(exp_ack));
    check_val("psum_out",     128'(psum_out),     128'(exp_out));
    check_val("col_count",    128'(col_count),    128'(exp_cnt));
    check_val("replay_done",  128'(replay_done),  128'(m_done));
    check_val("error",        128'(error),        128'(m_err));
    // Scoreboard: column-0 replay words in order.
    if (psum_out[0].valid) begin
      if (exp_q.size() == 0) begin
        check_val("sb_col0_unexpected_valid", 128'(psum_out[0].valid), 128'(1'b0));
      end else begin
        check_val("sb_col0_data", 128'(psum_out[0].data), 128'(exp_q[0]));
        if (psum_ack_in[0]) void'(exp_q.pop_front());
      end
    end
    // Advance the model across the clock edge.
    err_evt  = 1'b0;
    all_done = 1'b1;
    for (int j = 0; j < NUM_COLS; j++) begin
      if (psum_ack_in[j] && !exp_out[j].valid) err_evt = 1'b1;
      if ((m_st == S_REPLAY) && psum_in[j].valid) err_evt = 1'b1;
      if (m_rd[j] != m_cnt[j]) all_done = 1'b0;
    end
    clear  = change_mode && (mode == MODE1);
    rewind = conv_continue || (change_mode && (mode == MODE2));
    for (int j = 0; j < NUM_COLS; j++) begin
      if (exp_ack[j]) begin
        m_mem[j][m_wr[j]] = psum_in[j].data;
        m_wr[j]  = (m_wr[j] + 1) % DEPTH;
        m_cnt[j] = m_cnt[j] + 1;
      end
      if (clear) begin
        m_wr[j] = 0; m_rd[j] = 0; m_cnt[j] = 0;
      end else if (rewind) begin
        m_rd[j] = 0;
      end else if (exp_out[j].valid && psum_ack_in[j]) begin
        m_rd[j] = m_rd[j] + 1;
      end
    end
    if (clear || rewind) begin
      exp_q.delete();
      for (int k = 0; k < m_cnt[0]; k++) exp_q.push_back(m_mem[0][k]);
    end
    m_done = (m_st == S_REPLAY) && all_done;
    m_err  = m_err | err_evt;
    if (change_mode) begin
      case (mode)
        MODE1:   m_st = S_CAPTURE;
        MODE2:   m_st = S_REPLAY;
        default: m_st = S_IDLE;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic change_to(input OP_MODE m);
    mode = m; change_mode = 1'b1;
    cycle();
    change_mode = 1'b0;
  endtask

  initial begin
    do_reset();
    cycle();                                   // reset state

    // Capture 1..5 into column 0.
    change_to(MODE1);
    for (int i = 1; i <= 5; i++) begin
      psum_in[0] = {1'b1, 16'(i)};
      cycle();
    end
    psum_in[0] = '0;
    cycle();

    // Fill column 3 and push one word beyond full.
    for (int i = 0; i < 17; i++) begin
      psum_in[3] = {1'b1, 16'(16'h0100 + i)};
      cycle();
    end
    psum_in[3] = '0;
    cycle();

    // Replay: column 0 drains 5 words, column 3 drains 16.
    change_to(MODE2);
    for (int i = 0; i < 16; i++) begin
      psum_ack_in[0] = (i < 5);
      psum_ack_in[3] = 1'b1;
      cycle();
    end
    psum_ack_in = '0;
    for (int i = 0; i < 3; i++) cycle();

    // Rewind and replay column 0 again; rewind coinciding with an ack.
    conv_continue = 1'b1; cycle(); conv_continue = 1'b0;
    psum_ack_in[0] = 1'b1;
    cycle(); cycle();
    conv_continue = 1'b1; cycle(); conv_continue = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    psum_ack_in[0] = 1'b0;
    cycle(); cycle();

    // Ack on an empty column raises a sticky error.
    psum_ack_in[2] = 1'b1; cycle(); psum_ack_in[2] = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Reset clears everything.
    do_reset();
    cycle();

    // Mode change to capture while column 1 presents data.
    change_to(MODE1);
    psum_in[1] = {1'b1, 16'h0011}; cycle();
    psum_in[1] = {1'b1, 16'h0022}; cycle();
    psum_in[1] = {1'b1, 16'h0077};
    change_to(MODE1);
    cycle();
    psum_in[1] = '0;
    cycle();

    // Input valid during replay is a protocol error.
    change_to(MODE2);
    psum_in[4] = {1'b1, 16'h00AA}; cycle(); psum_in[4] = '0;
    psum_ack_in[1] = 1'b1; cycle(); psum_ack_in[1] = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_psum_buffer
